// File: rtl/wallace_pkg.sv
// Shared defaults and state type for the Wallace multiply-accumulate stage.
package wallace_pkg;

  localparam int PROD_W_DEF = 33;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/wallace_sat_add.sv
// Accumulator adder with carry-out detect; wraps by default,
// clamps to all ones when WALLACE_ACC_SAT_EN is defined.
module wallace_sat_add
  import wallace_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  localparam int EXT = ACC_W + 1 - PROD_W;

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + {{EXT{1'b0}}, b};
  assign carry = full[ACC_W];

`ifdef WALLACE_ACC_SAT_EN
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/wallace_acc_stage.sv
// Accumulates len unsigned products, then holds the sum for a
// valid/ready handoff. WALLACE_ACC_SAT_EN selects saturating add.
module wallace_acc_stage
  import wallace_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              p_valid,
  input  logic [PROD_W-1:0] p,
  output logic              busy,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;
  logic             len_zero;

  wallace_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a     (acc_q),
    .b     (p),
    .sum   (sum),
    .carry (carry)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign len_zero = (len == '0);

  // HOLD accepts a new start only together with the result handoff
  assign take = start &&
                ((state_q == IDLE) ||
                 (state_q == HOLD && acc_ready));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (start) state_d = len_zero ? HOLD : ACCUM;
      end
      state_q == ACCUM: begin
        if (p_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      state_q == HOLD: begin
        if (acc_ready) begin
          if (!start)        state_d = IDLE;
          else if (len_zero) state_d = HOLD;
          else               state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      len_d = len;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == ACCUM);
  assign acc_valid = (state_q == HOLD);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wallace_acc_stage.sv
// Directed bench for wallace_acc_stage with hand-computed sums.
module tb_wallace_acc_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        p_valid;
  logic [32:0] p;
  logic        busy;
  logic        acc_valid;
  logic        acc_ready;
  logic [39:0] acc;
  logic        ovf;

  int vecs;
  int miss;

  wallace_acc_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p         (p),
    .busy      (busy),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc       (acc),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic b, input logic v,
                         input logic [39:0] a, input logic o);
    chk({tag, ".busy"},      {63'd0, busy},      {63'd0, b});
    chk({tag, ".acc_valid"}, {63'd0, acc_valid}, {63'd0, v});
    chk({tag, ".acc"},       {24'd0, acc},       {24'd0, a});
    chk({tag, ".ovf"},       {63'd0, ovf},       {63'd0, o});
  endtask

  logic [39:0] ovf_exp;

  initial begin
    vecs = 0;
    miss = 0;
`ifdef WALLACE_ACC_SAT_EN
    ovf_exp = 40'hFF_FFFF_FFFF;
`else
    ovf_exp = 40'h01_FFFF_FF7F;
`endif
    rst_n = 1'b0; start = 1'b0; len = 8'd0;
    p_valid = 1'b0; p = '0; acc_ready = 1'b0;
    #3;
    chk_out("reset", 1'b0, 1'b0, 40'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // basic sum, first start right after reset release
    start = 1'b1; len = 8'd3;
    tick();
    chk_out("basic_start", 1'b1, 1'b0, 40'd0, 1'b0);
    start = 1'b0; p_valid = 1'b1; p = 33'h0_FFFE_0001;
    tick(); tick();
    chk_out("basic_2", 1'b1, 1'b0, 40'h1_FFFC_0002, 1'b0);
    tick();
    chk_out("basic_done", 1'b0, 1'b1, 40'h2_FFFA_0003, 1'b0);
    p_valid = 1'b0; acc_ready = 1'b1;
    tick();
    chk_out("basic_idle", 1'b0, 1'b0, 40'h2_FFFA_0003, 1'b0);

    // gaps and drops
    acc_ready = 1'b0; p_valid = 1'b1; p = 33'd100;
    tick();
    chk_out("idle_drop", 1'b0, 1'b0, 40'h2_FFFA_0003, 1'b0);
    start = 1'b1; len = 8'd2; p = 33'd50;
    tick();
    chk_out("gap_start", 1'b1, 1'b0, 40'd0, 1'b0);
    start = 1'b0; p_valid = 1'b0;
    tick();
    chk("gap_idle_acc", {24'd0, acc}, 64'd0);
    p_valid = 1'b1; p = 33'd5;
    tick();
    chk_out("gap_first", 1'b1, 1'b0, 40'd5, 1'b0);
    p_valid = 1'b0;
    tick();
    p_valid = 1'b1; p = 33'd7;
    tick();
    chk_out("gap_done", 1'b0, 1'b1, 40'd12, 1'b0);
    p = 33'd999; start = 1'b1; len = 8'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("hold_stall", 1'b0, 1'b1, 40'd12, 1'b0);
    end
    start = 1'b0; p_valid = 1'b0; acc_ready = 1'b1;
    tick();
    chk_out("gap_release", 1'b0, 1'b0, 40'd12, 1'b0);
    acc_ready = 1'b0;

    // overflow with 129 max products
    start = 1'b1; len = 8'd129;
    tick();
    start = 1'b0; p_valid = 1'b1; p = 33'h1_FFFF_FFFF;
    repeat (128) tick();
    chk_out("ovf_128", 1'b1, 1'b0, 40'hFF_FFFF_FF80, 1'b0);
    tick();
    chk_out("ovf_done", 1'b0, 1'b1, ovf_exp, 1'b1);

    // back-to-back restart clears overflow
    p_valid = 1'b0; acc_ready = 1'b1; start = 1'b1; len = 8'd1;
    tick();
    chk_out("b2b_start", 1'b1, 1'b0, 40'd0, 1'b0);
    acc_ready = 1'b0; start = 1'b0; p_valid = 1'b1; p = 33'd9;
    tick();
    chk_out("b2b_done", 1'b0, 1'b1, 40'd9, 1'b0);

    // 128 max products, no overflow
    p_valid = 1'b0; acc_ready = 1'b1; start = 1'b1; len = 8'd128;
    tick();
    acc_ready = 1'b0; start = 1'b0;
    p_valid = 1'b1; p = 33'h1_FFFF_FFFF;
    repeat (128) tick();
    chk_out("len128", 1'b0, 1'b1, 40'hFF_FFFF_FF80, 1'b0);

    // zero length, from HOLD then from IDLE
    p_valid = 1'b0; acc_ready = 1'b1; start = 1'b1; len = 8'd0;
    tick();
    chk_out("zero_b2b", 1'b0, 1'b1, 40'd0, 1'b0);
    start = 1'b0;
    tick();
    chk_out("zero_idle", 1'b0, 1'b0, 40'd0, 1'b0);
    acc_ready = 1'b0; start = 1'b1;
    tick();
    chk_out("zero_len", 1'b0, 1'b1, 40'd0, 1'b0);
    start = 1'b0; acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // reset in the middle of an accumulation
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0; p_valid = 1'b1; p = 33'd1;
    tick(); tick();
    chk_out("mid_run", 1'b1, 1'b0, 40'd2, 1'b0);
    p_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 40'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1;
    tick();
    chk_out("rst_start", 1'b1, 1'b0, 40'd0, 1'b0);
    start = 1'b0; p_valid = 1'b1; p = 33'd3;
    tick();
    chk_out("rst_done", 1'b0, 1'b1, 40'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
